// File: rtl/adc_sample_averager.sv
// Block averager behind the SAR controller: sums 2^LOG2_AVG codes and tracks min/max.
// Each finished block goes to a valid/ready holding register; a result that finds the register full is dropped and flagged.
module adc_sample_averager #(
  parameter int WIDTH    = 8,
  parameter int LOG2_AVG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_strobe,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [7:0]       block_cnt
);

  localparam int AW = WIDTH + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] avg_out_q, avg_out_d;
  logic [WIDTH-1:0] min_out_q, min_out_d;
  logic [WIDTH-1:0] max_out_q, max_out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       bcnt_q, bcnt_d;

  logic [AW-1:0]    sum;
  logic [WIDTH-1:0] smin, smax;
  logic             complete, drain, load, drop;

  // Floor mean: the shift by LOG2_AVG is just dropping the low bits of the sum.
  function automatic logic [WIDTH-1:0] block_mean(input logic [AW-1:0] s);
    return s[AW-1:LOG2_AVG];
  endfunction

  assign sum  = acc_q + AW'(sample_in);
  assign smin = (sample_in < min_q) ? sample_in : min_q;
  assign smax = (sample_in > max_q) ? sample_in : max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      avg_out_q <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      avg_out_q <= avg_out_d;
      min_out_q <= min_out_d;
      max_out_q <= max_out_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      bcnt_q    <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_ACCUM;
      S_ACCUM: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator: idle or disable parks it at the empty-block values.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    max_d    = max_q;
    complete = 1'b0;
    if (state_q != S_ACCUM || !enable) begin
      acc_d = '0;
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (sample_strobe) begin
      if (cnt_q == LAST_CNT) begin
        complete = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        min_d    = '1;
        max_d    = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        min_d = smin;
        max_d = smax;
      end
    end
  end

  assign drain = valid_q && avg_ready;
  assign load  = complete && (!valid_q || avg_ready);
  assign drop  = complete && valid_q && !avg_ready;

  // Holding register and status; a fresh result may replace one draining this cycle.
  always_comb begin
    avg_out_d = avg_out_q;
    min_out_d = min_out_q;
    max_out_d = max_out_q;
    valid_d   = valid_q;
    bcnt_d    = bcnt_q;
    if (load) begin
      avg_out_d = block_mean(sum);
      min_out_d = smin;
      max_out_d = smax;
      valid_d   = 1'b1;
      bcnt_d    = bcnt_q + 8'd1;
    end else if (drain) begin
      valid_d   = 1'b0;
    end
    if (drop)             ovr_d = 1'b1;
    else if (overrun_clr) ovr_d = 1'b0;
    else                  ovr_d = ovr_q;
  end

  assign avg_out   = avg_out_q;
  assign min_out   = min_out_q;
  assign max_out   = max_out_q;
  assign avg_valid = valid_q;
  assign overrun   = ovr_q;
  assign block_cnt = bcnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: directed scenarios plus random traffic against a block-level model.
module tb_adc_sample_averager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, sample_strobe, avg_ready, overrun_clr;
  logic [7:0] sample_in, avg_out, min_out, max_out, block_cnt;
  logic       avg_valid, overrun;

  logic       enable1, strobe1, avg_ready1, overrun_clr1;
  logic [7:0] sample_in1, avg_out1, min_out1, max_out1, block_cnt1;
  logic       avg_valid1, overrun1;

  int checks = 0;
  int errors = 0;

  adc_sample_averager #(.WIDTH(8), .LOG2_AVG(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
    .sample_strobe(sample_strobe), .avg_out(avg_out), .min_out(min_out),
    .max_out(max_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .block_cnt(block_cnt)
  );

  adc_sample_averager #(.WIDTH(8), .LOG2_AVG(0)) dut_pt (
    .clk(clk), .reset(reset), .enable(enable1), .sample_in(sample_in1),
    .sample_strobe(strobe1), .avg_out(avg_out1), .min_out(min_out1),
    .max_out(max_out1), .avg_valid(avg_valid1), .avg_ready(avg_ready1),
    .overrun(overrun1), .overrun_clr(overrun_clr1), .block_cnt(block_cnt1)
  );

  // Reference model: a queue holds the current block; results computed with plain arithmetic.
  bit         m_acc = 1'b0;
  logic [7:0] m_blk[$];
  logic [7:0] m_avg = 8'd0, m_min = 8'd0, m_max = 8'd0, m_cnt = 8'd0;
  logic       m_valid = 1'b0, m_ovr = 1'b0;

  task automatic model_step();
    int         s;
    logic [7:0] lo, hi;
    bit         done, dropped;
    done = 1'b0;
    s = 0; lo = 8'hFF; hi = 8'h00;
    if (reset) begin
      m_acc = 1'b0; m_blk.delete();
      m_avg = 0; m_min = 0; m_max = 0; m_cnt = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    if (!m_acc) begin
      m_acc = enable;
    end else if (!enable) begin
      m_acc = 1'b0; m_blk.delete();
    end else if (sample_strobe) begin
      m_blk.push_back(sample_in);
      if (m_blk.size() == 4) begin
        foreach (m_blk[i]) begin
          s += int'(m_blk[i]);
          if (m_blk[i] < lo) lo = m_blk[i];
          if (m_blk[i] > hi) hi = m_blk[i];
        end
        done = 1'b1;
        m_blk.delete();
      end
    end
    dropped = done && m_valid && !avg_ready;
    if (done && !dropped) begin
      m_avg = 8'(s / 4); m_min = lo; m_max = hi;
      m_valid = 1'b1; m_cnt = m_cnt + 8'd1;
    end else if (m_valid && avg_ready) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  // Inputs settle at the falling edge; the model consumes them before the rising edge.
  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] v);
    sample_in = v; sample_strobe = 1'b1;
    cycle();
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 0; sample_strobe = 0; sample_in = 0; avg_ready = 0; overrun_clr = 0;
    enable1 = 1'b1; strobe1 = 0; sample_in1 = 0; avg_ready1 = 1'b1; overrun_clr1 = 0;
    cycle(); cycle();
    reset = 1'b0;
    checks++; if (avg_valid !== 1'b0 || avg_valid1 !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b/%b need 0/0", avg_valid, avg_valid1); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun: got %b need 0", overrun); end
    checks++; if (block_cnt !== 8'd0) begin errors++;
      $display("FAIL reset_block_cnt: got %0d need 0", block_cnt); end
    checks++; if ({avg_out, min_out, max_out} !== 24'd0) begin errors++;
      $display("FAIL reset_data: got %0d/%0d/%0d need 0/0/0", avg_out, min_out, max_out); end
  endtask

  task automatic test_basic_mean();
    avg_ready = 1'b1; enable = 1'b1;
    cycle();
    strobe(8'd10); strobe(8'd20); strobe(8'd30);
    checks++; if (avg_valid !== 1'b0) begin errors++;
      $display("FAIL basic_early_valid: got %b need 0", avg_valid); end
    strobe(8'd41);
    checks++; if (avg_valid !== 1'b1) begin errors++;
      $display("FAIL basic_valid: got %b need 1", avg_valid); end
    checks++; if (avg_out !== 8'd25 || min_out !== 8'd10 || max_out !== 8'd41) begin errors++;
      $display("FAIL basic_result: got %0d/%0d/%0d need 25/10/41", avg_out, min_out, max_out); end
    checks++; if (block_cnt !== 8'd1) begin errors++;
      $display("FAIL basic_block_cnt: got %0d need 1", block_cnt); end
    cycle();
    checks++; if (avg_valid !== 1'b0) begin errors++;
      $display("FAIL basic_drain: got %b need 0", avg_valid); end
  endtask

  task automatic test_full_scale();
    repeat (4) strobe(8'd255);
    checks++; if (avg_out !== 8'd255 || min_out !== 8'd255 || max_out !== 8'd255) begin errors++;
      $display("FAIL fullscale: got %0d/%0d/%0d need 255/255/255", avg_out, min_out, max_out); end
    strobe(8'd0); strobe(8'd0); strobe(8'd0); strobe(8'd3);
    checks++; if (avg_out !== 8'd0 || min_out !== 8'd0 || max_out !== 8'd3 || block_cnt !== 8'd3) begin
      errors++;
      $display("FAIL truncation: got %0d/%0d/%0d cnt %0d need 0/0/3 cnt 3", avg_out, min_out, max_out, block_cnt);
    end
  endtask

  task automatic test_overrun();
    cycle();
    avg_ready = 1'b0;
    repeat (4) strobe(8'd100);
    checks++; if (avg_valid !== 1'b1 || avg_out !== 8'd100 || block_cnt !== 8'd4) begin errors++;
      $display("FAIL ovr_first: got v%b avg %0d cnt %0d need v1 avg 100 cnt 4", avg_valid, avg_out, block_cnt); end
    repeat (4) strobe(8'd200);
    checks++; if (avg_out !== 8'd100 || overrun !== 1'b1 || block_cnt !== 8'd4 || avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop: got avg %0d ovr %b cnt %0d v%b need 100 1 4 1", avg_out, overrun, block_cnt, avg_valid);
    end
    avg_ready = 1'b1; cycle(); avg_ready = 1'b0;
    checks++; if (avg_valid !== 1'b0 || overrun !== 1'b1) begin errors++;
      $display("FAIL ovr_transfer: got v%b ovr %b need v0 ovr 1", avg_valid, overrun); end
    overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL ovr_clear: got %b need 0", overrun); end
    repeat (4) strobe(8'd30);
    strobe(8'd40); strobe(8'd40); strobe(8'd40);
    overrun_clr = 1'b1; strobe(8'd40); overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b1 || avg_out !== 8'd30 || block_cnt !== 8'd5) begin errors++;
      $display("FAIL ovr_set_beats_clr: got ovr %b avg %0d cnt %0d need 1 30 5", overrun, avg_out, block_cnt); end
    overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;
  endtask

  task automatic test_drain_load();
    strobe(8'd60); strobe(8'd60); strobe(8'd60);
    avg_ready = 1'b1; strobe(8'd64); avg_ready = 1'b0;
    checks++; if (avg_valid !== 1'b1 || avg_out !== 8'd61 || min_out !== 8'd60 || max_out !== 8'd64) begin
      errors++;
      $display("FAIL drain_load: got v%b %0d/%0d/%0d need v1 61/60/64", avg_valid, avg_out, min_out, max_out);
    end
    checks++; if (overrun !== 1'b0 || block_cnt !== 8'd6) begin errors++;
      $display("FAIL drain_load_status: got ovr %b cnt %0d need 0 6", overrun, block_cnt); end
    avg_ready = 1'b1; cycle();
  endtask

  task automatic test_abort();
    strobe(8'd100); strobe(8'd100);
    enable = 1'b0; sample_in = 8'd255; sample_strobe = 1'b1; cycle();
    enable = 1'b1; cycle();
    sample_strobe = 1'b0;
    repeat (4) strobe(8'd8);
    checks++; if (avg_out !== 8'd8 || min_out !== 8'd8 || max_out !== 8'd8 || block_cnt !== 8'd7) begin
      errors++;
      $display("FAIL abort: got %0d/%0d/%0d cnt %0d need 8/8/8 cnt 7", avg_out, min_out, max_out, block_cnt);
    end
  endtask

  task automatic test_reset_mid();
    avg_ready = 1'b0;
    repeat (4) strobe(8'd5);
    strobe(8'd9); strobe(8'd9);
    reset = 1'b1; sample_in = 8'd9; sample_strobe = 1'b1; cycle();
    reset = 1'b0; sample_strobe = 1'b0;
    checks++; if (avg_valid !== 1'b0 || overrun !== 1'b0 || block_cnt !== 8'd0 ||
                  {avg_out, min_out, max_out} !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid: got v%b ovr %b cnt %0d %0d/%0d/%0d need all 0",
               avg_valid, overrun, block_cnt, avg_out, min_out, max_out);
    end
    avg_ready = 1'b1; cycle();
    strobe(8'd1); strobe(8'd2); strobe(8'd3); strobe(8'd6);
    checks++; if (avg_out !== 8'd3 || min_out !== 8'd1 || max_out !== 8'd6 || block_cnt !== 8'd1) begin
      errors++;
      $display("FAIL reset_fresh_block: got %0d/%0d/%0d cnt %0d need 3/1/6 cnt 1", avg_out, min_out, max_out, block_cnt);
    end
  endtask

  task automatic test_passthrough();
    cycle();
    sample_in1 = 8'd7; strobe1 = 1'b1; cycle();
    checks++; if (avg_valid1 !== 1'b1 || avg_out1 !== 8'd7 || min_out1 !== 8'd7 || max_out1 !== 8'd7 ||
                  block_cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL pass_first: got v%b %0d/%0d/%0d cnt %0d need v1 7/7/7 cnt 1",
               avg_valid1, avg_out1, min_out1, max_out1, block_cnt1);
    end
    sample_in1 = 8'd200; cycle(); strobe1 = 1'b0;
    checks++; if (avg_valid1 !== 1'b1 || avg_out1 !== 8'd200 || min_out1 !== 8'd200 || max_out1 !== 8'd200 ||
                  block_cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL pass_second: got v%b %0d/%0d/%0d cnt %0d need v1 200/200/200 cnt 2",
               avg_valid1, avg_out1, min_out1, max_out1, block_cnt1);
    end
    cycle();
    checks++; if (avg_valid1 !== 1'b0) begin errors++;
      $display("FAIL pass_drain: got %b need 0", avg_valid1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable        = ($urandom_range(0, 19) != 0);
      sample_strobe = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       sample_in = 8'd0;
        1:       sample_in = 8'd255;
        default: sample_in = 8'($urandom);
      endcase
      avg_ready   = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 249) == 0);
      cycle();
      checks++;
      if ({avg_valid, avg_out, min_out, max_out, overrun, block_cnt} !==
          {m_valid, m_avg, m_min, m_max, m_ovr, m_cnt}) begin
        errors++;
        $display("FAIL random_cycle_%0d: got v%b %0d/%0d/%0d ovr %b cnt %0d need v%b %0d/%0d/%0d ovr %b cnt %0d",
                 i, avg_valid, avg_out, min_out, max_out, overrun, block_cnt,
                 m_valid, m_avg, m_min, m_max, m_ovr, m_cnt);
      end
    end
    reset = 1'b0; sample_strobe = 1'b0; overrun_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_mean();
    test_full_scale();
    test_overrun();
    test_drain_load();
    test_abort();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Block-averaging stage directly downstream of the SAR conversion controller. It captures each finished conversion code on the controller's one-cycle completion strobe and accumulates 2^LOG2_AVG consecutive codes. It then presents the truncated mean with the block minimum and maximum through a valid/ready output holding register. If the consumer stalls, completed results are dropped and counted as overruns.

## Interface
- WIDTH, 8, sample code width; matches the SAR controller code width
- LOG2_AVG, 2, log2 of samples per block; legal range 0..8 (0 = pass-through, block of 1)

- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- enable  input  1  1 = accumulate; 0 = idle, partial block discarded
- sample_in  input  WIDTH  conversion code; valid only when sample_strobe=1
- sample_strobe  input  1  one-cycle strobe per finished conversion, the SAR ready pulse
- avg_out  output  WIDTH  block mean, truncated
- min_out  output  WIDTH  smallest sample in the block
- max_out  output  WIDTH  largest sample in the block
- avg_valid  output  1  holding register full
- avg_ready  input  1  consumer accepts; transfer when avg_valid & avg_ready
- overrun  output  1  sticky; a completed block was dropped
- overrun_clr  input  1  clears overrun; set takes priority in the same cycle
- block_cnt  output  8  count of results produced since reset, wraps 255->0; dropped blocks are not counted

## Operation
- Internal registers:
  - accumulator acc, width WIDTH+LOG2_AVG; cannot overflow, since max sum = (2^WIDTH-1)*2^LOG2_AVG
  - sample counter cnt, width max(LOG2_AVG,1)
  - running min and max
- FSM states:
  - S_IDLE: acc=0, cnt=0, min=all-ones, max=0. Goes to S_ACCUM when enable=1. Strobes are ignored while in S_IDLE.
  - S_ACCUM, on each strobe:
    - acc += sample_in
    - min = min(min, sample_in); max = max(max, sample_in)
    - cnt += 1
  - S_ACCUM, on the strobe with cnt == 2^LOG2_AVG-1 (the last sample):
    - the final sum, min and max include that sample
    - completion logic fires, then acc/cnt/min/max reinitialise and the FSM stays in S_ACCUM
  - S_ACCUM with enable=0: go to S_IDLE and discard the partial block. A strobe in that same cycle is ignored.
- Completion logic:
  - Result: avg = final_sum >> LOG2_AVG (floor), plus the final min and max.
  - Holding register empty, or draining this cycle (avg_valid & avg_ready): load avg_out/min_out/max_out, set avg_valid, block_cnt += 1.
  - Holding register full and not draining: drop the new result, set overrun, leave the holding register unchanged.
- Holding register: cleared by avg_valid & avg_ready unless reloaded in the same cycle. Its contents stay stable while avg_valid=1 and avg_ready=0.
- Reset values:
  - state S_IDLE, acc/cnt 0
  - avg_out, min_out, max_out 0
  - avg_valid 0, overrun 0, block_cnt 0

## Timing
- Latency: avg_valid rises on the clock edge after the cycle in which the final sample_strobe is high; it is 1 in the following cycle.
- Back-to-back strobes on consecutive cycles are supported; every strobe is accepted in S_ACCUM.
- First block after enable rises: the FSM needs one cycle to enter S_ACCUM. A strobe in the cycle enable first goes high is ignored.
- Simultaneous completion and drain: the new result loads, avg_valid stays 1, no overrun.
- overrun set and overrun_clr in the same cycle: overrun ends up 1.
- reset mid-block or with avg_valid=1: everything returns to reset values on that edge, with no result or overrun produced.
- LOG2_AVG=0:
  - every strobe completes a block; avg_out = min_out = max_out = sample_in
  - cnt stays 0

## Test plan
- Basic mean, WIDTH=8, LOG2_AVG=2, avg_ready=1, enable=1: strobe 10, 20, 30, 41 → one cycle after the 4th strobe avg_valid=1, avg_out=25 (101>>2), min_out=10, max_out=41, block_cnt=1.
- Full-scale/truncation: four strobes of 255 → avg_out=255, no wrap. Then 0, 0, 0, 3 → avg_out=0, min_out=0, max_out=3.
- Backpressure/overrun: avg_ready=0, two full blocks (first block 4×100, second 4×200) → holding register keeps avg_out=100, overrun=1, block_cnt=1. Then avg_ready=1 → transfer, avg_valid=0. Then overrun_clr=1 → overrun=0.
- Simultaneous drain and load: avg_valid=1 with avg_ready pulsed in the cycle of the final strobe of the next block → new avg_out loaded, avg_valid stays 1, overrun=0, block_cnt increments.
- Abort:
  - enable dropped after 2 of 4 strobes, then restored → the next 4 strobes (8, 8, 8, 8) give avg_out=8; the stale partial sum is not included.
  - reset asserted mid-block → all outputs at reset values on the next cycle.
- Pass-through, LOG2_AVG=0: strobes 7, 200 on consecutive cycles with avg_ready=1 → avg_out 7 then 200, each valid one cycle after its strobe, block_cnt=2.
